time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Free-running 24-hour BCD timekeeper for the DE2 digital clock.
- Divides CLOCK_50 down to 1 Hz and counts seconds, minutes and hours in BCD.
- Supports manual digit-by-digit setting.
- Drives second/minute/hour directly into the alarm stage and the LCD data path, plus a per-second tick and an hourly chime pulse.

Parameters:
- DIV, 50000000: CLOCK_50 cycles per second; benches override it to a small value (e.g. 4).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- clr_n  input  1  reset, asynchronous, active-low
- adjust  input  1  high = time-setting mode; counting halted
- select_add  input  1  rising edge advances the digit select (adjust mode only); asynchronous, already debounced
- add  input  1  rising edge increments the selected digit (adjust mode only); asynchronous, already debounced
- second  output  7  BCD seconds, [6:4] tens, [3:0] units
- minute  output  7  BCD minutes, [6:4] tens, [3:0] units
- hour  output  6  BCD hours, [5:4] tens, [3:0] units
- select_one  output  4  one-hot digit being set (for LCD blink): bit0 min units, bit1 min tens, bit2 hour units, bit3 hour tens; 0 when adjust=0
- tick  output  1  one-cycle pulse at each seconds increment
- chime  output  1  one-cycle pulse when time rolls to xx:00:00 by counting

Behaviour:
- Single clock domain CLOCK_50.
- clr_n low (async) forces:
  - second, minute, hour = 00:00:00
  - prescaler = 0, select = 0
  - tick = 0, chime = 0
  - all synchronizer and edge flops = 0
- adjust, select_add and add each pass through a 2-flop synchronizer, then an edge detector (sync2 & ~prev).
  - A rising input sampled at edge k takes effect at clock edge k+2.
  - Edges arriving while adjust(synced)=0 are ignored.
- Run mode (adjust synced = 0):
  - Prescaler counts 0..DIV-1.
  - At DIV-1 it wraps to 0 and, in the same edge, tick=1 and seconds increment.
- BCD counting rules:
  - units 9→0 with carry to tens
  - seconds/minutes tens 5→0 with carry to the next field
  - hour 23→00
- Rollover 23:59:59 → 00:00:00 in one edge.
- chime=1 in the same cycle that minute and second both become 00 via counting. Never asserted in adjust mode or by reset.
- Adjust mode (adjust synced = 1):
  - Prescaler held at 0; tick=0.
  - Second held at its current value.
  - Rising edge of adjust clears select to 0.
  - select_add edge: select = select+1 mod 4.
  - add edge increments only the selected digit, with no carry into any neighbour:
    - min units: 9→0
    - min tens: 5→0
    - hour units: 9→0 if hour tens<2; 3→0 if hour tens=2
    - hour tens: 0→1→2→0; when stepping to 2 with hour units>3, hour units forced to 0 in the same edge
  - add and select_add edges in the same cycle: increment applies to the old select; select advances in that edge.
- Falling edge of adjust (leaving adjust mode):
  - second cleared to 00 and prescaler restarts from 0.
  - First tick comes exactly DIV cycles later.
- select_one = one-hot(select) when adjust synced = 1, else 4'b0000. Registered, no glitches.
- Invariant: outputs never show an illegal BCD or time value (hour ≤ 23, min/sec ≤ 59, units ≤ 9).

Test Plan:
- Reset and first tick (DIV=4): assert clr_n low mid-count → all outputs 0 immediately; release → second=01 and tick=1 on the 4th edge, second=02 four edges later.
- Full rollover: preset 23:59:58 via adjust, run 2 seconds → 23:59:59, then 00:00:00 with tick=1 and chime=1 in the same cycle; chime low otherwise.
- Carry check: run from 00:09:59 → 00:10:00 (chime=0); from 09:59:59 → 10:00:00 (chime=1).
- Adjust digits: adjust=1, select_one=0001; add ×12 → minute units cycles to 2 (wraps at 9); select_add ×3 → select_one=1000; add ×2 → hour=2x; with hour units preset to 7 → hour becomes 20.
- Hour units limit: hour=20, select hour units, add ×5 → 21, 22, 23, 20, 21; minute and second unchanged throughout.
- Edge cases:
  - add pulse while adjust=0 → no change.
  - add and select_add rising together → old digit increments, select advances.
  - Release adjust → second=00 and next tick after DIV cycles.

Source files
------------

// File: rtl/time_keeper_if.sv
// time_keeper_if: setting controls in, time/tick/chime out.
// master drives the controls, slave is the timekeeper.
interface time_keeper_if;
   logic       adjust;
   logic       select_add;
   logic       add;
   logic [6:0] second;
   logic [6:0] minute;
   logic [5:0] hour;
   logic [3:0] select_one;
   logic       tick;
   logic       chime;

   modport master (
      output adjust, select_add, add,
      input  second, minute, hour, select_one, tick, chime
   );

   modport slave (
      input  adjust, select_add, add,
      output second, minute, hour, select_one, tick, chime
   );
endinterface

// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD timekeeper with a 1 Hz prescaler
// and digit-by-digit manual setting.
module time_keeper #(
   parameter int DIV = 50000000
) (
   input  logic         CLOCK_50,
   input  logic         clr_n,
   time_keeper_if.slave tk
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   // [0] first sync flop, [1] second sync flop, [2] previous value
   logic [2:0] adj_sh, sel_sh, add_sh;
   logic       adj, adj_rise, adj_fall, sel_e, add_e;

   logic [PW-1:0] presc, presc_n;
   logic [6:0]    sec_q, sec_n, min_q, min_n;
   logic [5:0]    hr_q, hr_n;
   logic [1:0]    sel, sel_n;
   logic [3:0]    sel_one, sel_one_n;
   logic          tick_q, tick_n, chime_q, chime_n;
   logic [3:0]    hu_max;

   assign adj      = adj_sh[1];
   assign adj_rise = adj_sh[1] & ~adj_sh[2];
   assign adj_fall = ~adj_sh[1] & adj_sh[2];
   assign sel_e    = sel_sh[1] & ~sel_sh[2] & adj;
   assign add_e    = add_sh[1] & ~add_sh[2] & adj;
   assign hu_max   = (hr_q[5:4] == 2'd2) ? 4'd3 : 4'd9;

   always_comb begin
      presc_n   = presc;
      sec_n     = sec_q;
      min_n     = min_q;
      hr_n      = hr_q;
      sel_n     = sel;
      tick_n    = 1'b0;
      chime_n   = 1'b0;
      if (adj_fall) begin
         sec_n   = '0;
         presc_n = '0;
      end else if (!adj) begin
         if (presc == LAST) begin
            presc_n = '0;
            tick_n  = 1'b1;
            if (sec_q[3:0] != 4'd9) begin
               sec_n[3:0] = sec_q[3:0] + 4'd1;
            end else begin
               sec_n[3:0] = 4'd0;
               if (sec_q[6:4] != 3'd5) begin
                  sec_n[6:4] = sec_q[6:4] + 3'd1;
               end else begin
                  sec_n[6:4] = 3'd0;
                  if (min_q[3:0] != 4'd9) begin
                     min_n[3:0] = min_q[3:0] + 4'd1;
                  end else begin
                     min_n[3:0] = 4'd0;
                     if (min_q[6:4] != 3'd5) begin
                        min_n[6:4] = min_q[6:4] + 3'd1;
                     end else begin
                        min_n[6:4] = 3'd0;
                        chime_n    = 1'b1;
                        if (hr_q == 6'h23)
                           hr_n = 6'h00;
                        else if (hr_q[3:0] == 4'd9)
                           hr_n = {hr_q[5:4] + 2'd1, 4'd0};
                        else
                           hr_n[3:0] = hr_q[3:0] + 4'd1;
                     end
                  end
               end
            end
         end else begin
            presc_n = presc + 1'b1;
         end
      end else begin
         presc_n = '0;
         if (adj_rise) begin
            sel_n = 2'd0;
         end else begin
            // increment uses the select held before this edge
            if (add_e) begin
               unique case (sel)
                  2'd0: min_n[3:0] = (min_q[3:0] == 4'd9) ?
                                     4'd0 : min_q[3:0] + 4'd1;
                  2'd1: min_n[6:4] = (min_q[6:4] == 3'd5) ?
                                     3'd0 : min_q[6:4] + 3'd1;
                  2'd2: hr_n[3:0]  = (hr_q[3:0] >= hu_max) ?
                                     4'd0 : hr_q[3:0] + 4'd1;
                  default: begin
                     unique case (hr_q[5:4])
                        2'd0: hr_n[5:4] = 2'd1;
                        2'd1: begin
                           hr_n[5:4] = 2'd2;
                           if (hr_q[3:0] > 4'd3) hr_n[3:0] = 4'd0;
                        end
                        default: hr_n[5:4] = 2'd0;
                     endcase
                  end
               endcase
            end
            if (sel_e) sel_n = sel + 2'd1;
         end
      end
      sel_one_n = adj ? (4'b0001 << sel_n) : 4'b0000;
   end

   always_ff @(posedge CLOCK_50 or negedge clr_n) begin
      if (!clr_n) begin
         adj_sh  <= '0;
         sel_sh  <= '0;
         add_sh  <= '0;
         presc   <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         sel     <= '0;
         sel_one <= '0;
         tick_q  <= 1'b0;
         chime_q <= 1'b0;
      end else begin
         adj_sh  <= {adj_sh[1:0], tk.adjust};
         sel_sh  <= {sel_sh[1:0], tk.select_add};
         add_sh  <= {add_sh[1:0], tk.add};
         presc   <= presc_n;
         sec_q   <= sec_n;
         min_q   <= min_n;
         hr_q    <= hr_n;
         sel     <= sel_n;
         sel_one <= sel_one_n;
         tick_q  <= tick_n;
         chime_q <= chime_n;
      end
   end

   assign tk.second     = sec_q;
   assign tk.minute     = min_q;
   assign tk.hour       = hr_q;
   assign tk.select_one = sel_one;
   assign tk.tick       = tick_q;
   assign tk.chime      = chime_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed stimulus with queued expectations,
// checked by tick and snapshot monitors.
module tb_time_keeper;
   localparam int DIV = 4;

   typedef struct {
      int         cyc;
      logic [5:0] h;
      logic [6:0] m;
      logic [6:0] s;
      logic [3:0] so;
      logic       ch;
      string      nm;
   } exp_t;

   logic clk;
   logic clr_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   exp_t tick_q[$];
   exp_t snap_q[$];
   event snap_ev;

   time_keeper_if tk();

   time_keeper #(.DIV(DIV)) dut (
      .CLOCK_50 (clk),
      .clr_n    (clr_n),
      .tk       (tk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input int c, input logic [5:0] h,
                               input logic [6:0] m, input logic [6:0] s,
                               input logic [3:0] so, input logic ch,
                               input string nm);
      exp_t e;
      e.cyc = c;
      e.h   = h;
      e.m   = m;
      e.s   = s;
      e.so  = so;
      e.ch  = ch;
      e.nm  = nm;
      return e;
   endfunction

   function automatic logic [6:0] bcd(input int v);
      return {3'(v / 10), 4'(v % 10)};
   endfunction

   task automatic compare(input exp_t e, input bit is_tick);
      bit bad;
      bad = 1'b0;
      vectors++;
      if (is_tick && cyc != e.cyc) bad = 1'b1;
      if (is_tick && tk.chime !== e.ch) bad = 1'b1;
      if (tk.second !== e.s || tk.minute !== e.m ||
          tk.hour !== e.h || tk.select_one !== e.so) bad = 1'b1;
      if (bad) begin
         miscompares++;
         $display("FAIL %s: got cyc=%0d %h:%h:%h sel=%b chime=%b, want cyc=%0d %h:%h:%h sel=%b chime=%b",
                  e.nm, cyc, tk.hour, tk.minute, tk.second, tk.select_one,
                  tk.chime, e.cyc, e.h, e.m, e.s, e.so, e.ch);
      end
   endtask

   always @(negedge clk) begin
      if (tk.chime === 1'b1 && tk.tick !== 1'b1) begin
         miscompares++;
         $display("FAIL chime_without_tick: got chime=1 at cyc=%0d, want 0", cyc);
      end
      if (tk.tick === 1'b1) begin
         if (tick_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tick: got tick=1 at cyc=%0d, want 0", cyc);
         end else begin
            compare(tick_q.pop_front(), 1'b1);
         end
      end
   end

   initial begin
      forever begin
         @(snap_ev);
         if (snap_q.size() != 0) compare(snap_q.pop_front(), 1'b0);
      end
   end

   task automatic snap_at(input int c, input string nm, input logic [5:0] h,
                          input logic [6:0] m, input logic [6:0] s,
                          input logic [3:0] so);
      while (cyc < c) @(negedge clk);
      #1;
      snap_q.push_back(mk(0, h, m, s, so, 1'b0, nm));
      -> snap_ev;
   endtask

   task automatic snap(input string nm, input logic [5:0] h,
                       input logic [6:0] m, input logic [6:0] s,
                       input logic [3:0] so);
      snap_at(cyc + 1, nm, h, m, s, so);
   endtask

   task automatic pulse(input bit a, input bit s);
      @(negedge clk);
      tk.add        = a;
      tk.select_add = s;
      repeat (3) @(negedge clk);
      tk.add        = 1'b0;
      tk.select_add = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // ticks 1..59 at hh:mm, then the minute rollover at tick 60
   task automatic push_min(input int e, input logic [5:0] h,
                           input logic [6:0] m, input logic [5:0] h2,
                           input logic [6:0] m2, input logic ch,
                           input string nm);
      for (int i = 1; i < 60; i++)
         tick_q.push_back(mk(e + DIV * i, h, m, bcd(i), 4'b0, 1'b0, nm));
      tick_q.push_back(mk(e + DIV * 60, h2, m2, 7'h00, 4'b0, ch,
                          {nm, "_roll"}));
   endtask

   initial begin
      int r;
      int f;
      logic [5:0] hseq [5];
      hseq = '{6'h21, 6'h22, 6'h23, 6'h20, 6'h21};
      vectors       = 0;
      miscompares   = 0;
      clr_n         = 1'b0;
      tk.adjust     = 1'b0;
      tk.add        = 1'b0;
      tk.select_add = 1'b0;

      repeat (3) @(negedge clk);
      snap("reset_state", 6'h00, 7'h00, 7'h00, 4'b0000);

      @(negedge clk);
      clr_n = 1'b1;
      r = cyc;
      tick_q.push_back(mk(r + 4, 6'h00, 7'h00, 7'h01, 4'b0, 1'b0, "first_tick"));
      tick_q.push_back(mk(r + 8, 6'h00, 7'h00, 7'h02, 4'b0, 1'b0, "second_tick"));
      pulse(1'b1, 1'b0);
      snap("add_in_run_ignored", 6'h00, 7'h00, 7'h02, 4'b0000);
      while (cyc < r + 10) @(negedge clk);
      @(posedge clk);
      #2 clr_n = 1'b0;
      snap("async_clear", 6'h00, 7'h00, 7'h00, 4'b0000);

      repeat (2) @(negedge clk);
      clr_n     = 1'b1;
      tk.adjust = 1'b1;
      repeat (3) @(negedge clk);
      snap("adj_entry", 6'h00, 7'h00, 7'h00, 4'b0001);
      repeat (12) pulse(1'b1, 1'b0);
      snap("min_units_wrap", 6'h00, 7'h02, 7'h00, 4'b0001);
      repeat (7) pulse(1'b1, 1'b0);
      snap("min_units_9", 6'h00, 7'h09, 7'h00, 4'b0001);
      pulse(1'b0, 1'b1);
      snap("sel_min_tens", 6'h00, 7'h09, 7'h00, 4'b0010);
      repeat (4) pulse(1'b1, 1'b0);
      snap("min_tens_4", 6'h00, 7'h49, 7'h00, 4'b0010);
      pulse(1'b1, 1'b1);
      snap("add_and_sel_same", 6'h00, 7'h59, 7'h00, 4'b0100);
      repeat (7) pulse(1'b1, 1'b0);
      snap("hour_units_7", 6'h07, 7'h59, 7'h00, 4'b0100);
      pulse(1'b0, 1'b1);
      snap("sel_hour_tens", 6'h07, 7'h59, 7'h00, 4'b1000);
      pulse(1'b1, 1'b0);
      snap("hour_tens_1", 6'h17, 7'h59, 7'h00, 4'b1000);
      pulse(1'b1, 1'b0);
      snap("hour_tens_2_clamp", 6'h20, 7'h59, 7'h00, 4'b1000);
      repeat (3) pulse(1'b0, 1'b1);
      snap("sel_wrap", 6'h20, 7'h59, 7'h00, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         pulse(1'b1, 1'b0);
         snap("hour_units_limit", hseq[i], 7'h59, 7'h00, 4'b0100);
      end
      repeat (2) pulse(1'b1, 1'b0);
      snap("preset_2359", 6'h23, 7'h59, 7'h00, 4'b0100);

      @(negedge clk);
      tk.adjust = 1'b0;
      f = cyc;
      push_min(f + 3, 6'h23, 7'h59, 6'h00, 7'h00, 1'b1, "day_roll");
      tick_q.push_back(mk(f + 247, 6'h00, 7'h00, 7'h01, 4'b0, 1'b0, "after_roll"));
      tick_q.push_back(mk(f + 251, 6'h00, 7'h00, 7'h02, 4'b0, 1'b0, "after_roll"));
      snap_at(f + 3, "release_clear", 6'h23, 7'h59, 7'h00, 4'b0000);
      while (cyc < f + 251) @(negedge clk);
      tk.adjust = 1'b1;

      repeat (10) @(negedge clk);
      snap("sec_held", 6'h00, 7'h00, 7'h02, 4'b0001);
      repeat (8) @(negedge clk);
      snap("sec_held_still", 6'h00, 7'h00, 7'h02, 4'b0001);
      repeat (9) pulse(1'b1, 1'b0);
      snap("set_0009", 6'h00, 7'h09, 7'h02, 4'b0001);
      @(negedge clk);
      tk.adjust = 1'b0;
      f = cyc;
      push_min(f + 3, 6'h00, 7'h09, 6'h00, 7'h10, 1'b0, "min_carry");
      snap_at(f + 3, "release_sec_clear", 6'h00, 7'h09, 7'h00, 4'b0000);
      while (cyc < f + 243) @(negedge clk);
      tk.adjust = 1'b1;

      repeat (5) @(negedge clk);
      snap("adj_reentry", 6'h00, 7'h10, 7'h00, 4'b0001);
      repeat (9) pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      repeat (4) pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      repeat (9) pulse(1'b1, 1'b0);
      snap("set_0959", 6'h09, 7'h59, 7'h00, 4'b0100);
      @(negedge clk);
      tk.adjust = 1'b0;
      f = cyc;
      push_min(f + 3, 6'h09, 7'h59, 6'h10, 7'h00, 1'b1, "hour_carry");
      snap_at(f + 3, "release_0959", 6'h09, 7'h59, 7'h00, 4'b0000);
      while (cyc < f + 245) @(negedge clk);

      while (tick_q.size() != 0) begin
         exp_t e;
         e = tick_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_tick %s: got none, want tick at cyc=%0d", e.nm, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
